crop_sequencer: RTL

//  Run-time scheduler for the crop_plus_fifo datapath; sequences up to MAX_CROPS crop windows over one source image.

---
 rtl/crop_pkg.sv | 33 +++
 rtl/crop_coord_table.sv | 60 ++++++
 rtl/crop_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/crop_pkg.sv
// Shared types and default geometry for the crop sequencer slice.
package crop_pkg;

   localparam int CROP_IN_ROWS   = 100;
   localparam int CROP_IN_COLS   = 160;
   localparam int CROP_OUT_ROWS  = 48;
   localparam int CROP_OUT_COLS  = 48;
   localparam int CROP_MAX_CROPS = 8;
   localparam int CROP_TIMEOUT   = 65535;

   localparam int CROP_YW = $clog2(CROP_IN_ROWS);
   localparam int CROP_XW = $clog2(CROP_IN_COLS);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      ARM,
      RUN,
      NEXT,
      FIN
   } seq_state_e;

   typedef struct packed {
      logic [CROP_YW-1:0] y;
      logic [CROP_XW-1:0] x;
   } crop_coord_t;

   // Index width that stays legal for a single-entry table.
   function automatic int clog2_min1(input int v);
      return (v <= 1) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/crop_coord_table.sv
// Origin table: MAX_CROPS entries, append-only write pointer, clear, and window range check.
module crop_coord_table
   import crop_pkg::*;
#(
   parameter int IN_ROWS   = CROP_IN_ROWS,
   parameter int IN_COLS   = CROP_IN_COLS,
   parameter int OUT_ROWS  = CROP_OUT_ROWS,
   parameter int OUT_COLS  = CROP_OUT_COLS,
   parameter int MAX_CROPS = CROP_MAX_CROPS,
   parameter int IW        = clog2_min1(MAX_CROPS),
   parameter int CW        = $clog2(MAX_CROPS + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          wr_en,
   input  crop_coord_t   wr_coord,
   input  logic [IW-1:0] rd_idx,
   output crop_coord_t   rd_coord,
   output logic [CW-1:0] count,
   output logic [CW-1:0] count_next,
   output logic          full,
   output logic          reject
);

   crop_coord_t tab [MAX_CROPS];
   logic        in_range;
   logic        do_write;

   assign in_range = (int'(wr_coord.y) + OUT_ROWS <= IN_ROWS) &&
                     (int'(wr_coord.x) + OUT_COLS <= IN_COLS);

   // A clear in the same cycle suppresses both the write and the error.
   assign do_write = wr_en && in_range && !clear;
   assign reject   = wr_en && !in_range && !clear;

   always_comb begin
      count_next = count;
      if (clear)
         count_next = '0;
      else if (do_write)
         count_next = count + CW'(1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else
         count <= count_next;
   end

   always_ff @(posedge clk) begin
      if (do_write)
         tab[count[IW-1:0]] <= wr_coord;
   end

   assign rd_coord = tab[rd_idx];
   assign full     = (count == CW'(MAX_CROPS));

endmodule

// File: rtl/crop_sequencer.sv
// Crop window scheduler: replays the source frame once per table entry and counts output beats.
// Optional watchdog on stalled output streams: define CROP_SEQ_TIMEOUT_EN.
module crop_sequencer
   import crop_pkg::*;
#(
   parameter int IN_ROWS        = CROP_IN_ROWS,
   parameter int IN_COLS        = CROP_IN_COLS,
   parameter int OUT_ROWS       = CROP_OUT_ROWS,
   parameter int OUT_COLS       = CROP_OUT_COLS,
   parameter int MAX_CROPS      = CROP_MAX_CROPS,
   parameter int TIMEOUT_CYCLES = CROP_TIMEOUT,
   parameter int YW             = $clog2(IN_ROWS),
   parameter int XW             = $clog2(IN_COLS),
   parameter int IW             = clog2_min1(MAX_CROPS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_valid,
   output logic          cfg_ready,
   input  logic [YW-1:0] cfg_y,
   input  logic [XW-1:0] cfg_x,
   input  logic          cfg_clear,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          frame_req,
   input  logic          frame_ack,
   output logic [YW-1:0] crop_y1,
   output logic [XW-1:0] crop_x1,
   output logic          crop_start,
   output logic [IW-1:0] crop_id,
   input  logic          beat_valid,
   input  logic          beat_ready,
   output logic          crop_done
);

   localparam int CW    = $clog2(MAX_CROPS + 1);
   localparam int TOTAL = OUT_ROWS * OUT_COLS;
   localparam int BW    = clog2_min1(TOTAL);

   seq_state_e    state, state_next;
   logic [CW-1:0] idx;
   logic [BW-1:0] beat_cnt;
   logic          err_q;

   crop_coord_t   rd_coord;
   logic [CW-1:0] tbl_count, tbl_count_next;
   logic          tbl_full, tbl_reject;
   logic          wr_en, clear, beat, last_beat, timeout;

   assign cfg_ready = (state == IDLE) && !tbl_full;
   assign wr_en     = cfg_valid && cfg_ready;
   assign clear     = cfg_clear && (state == IDLE);
   assign beat      = beat_valid && beat_ready;
   assign last_beat = (state == RUN) && beat && (beat_cnt == BW'(TOTAL - 1));

   crop_coord_table #(
      .IN_ROWS  (IN_ROWS),
      .IN_COLS  (IN_COLS),
      .OUT_ROWS (OUT_ROWS),
      .OUT_COLS (OUT_COLS),
      .MAX_CROPS(MAX_CROPS),
      .IW       (IW),
      .CW       (CW)
   ) u_table (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .wr_en     (wr_en),
      .wr_coord  ('{y: CROP_YW'(cfg_y), x: CROP_XW'(cfg_x)}),
      .rd_idx    (idx[IW-1:0]),
      .rd_coord  (rd_coord),
      .count     (tbl_count),
      .count_next(tbl_count_next),
      .full      (tbl_full),
      .reject    (tbl_reject)
   );

`ifdef CROP_SEQ_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] idle_cnt;

   always_ff @(posedge clk) begin
      if (reset || state != RUN || beat)
         idle_cnt <= '0;
      else
         idle_cnt <= idle_cnt + TW'(1);
   end

   assign timeout = (state == RUN) && !beat && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
   // Watchdog compiled out: RUN waits for beats indefinitely.
   assign timeout = (TIMEOUT_CYCLES < 0);
`endif

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: if (start) state_next = (tbl_count_next == '0) ? FIN : REQ;
         REQ:  if (frame_ack) state_next = ARM;
         ARM:  state_next = RUN;
         RUN: begin
            if (last_beat)
               state_next = NEXT;
            else if (timeout)
               state_next = FIN;
         end
         NEXT: state_next = (idx + CW'(1) == tbl_count) ? FIN : REQ;
         FIN:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         idx      <= '0;
         beat_cnt <= '0;
         err_q    <= 1'b0;
         crop_y1  <= '0;
         crop_x1  <= '0;
         crop_id  <= '0;
      end else begin
         state <= state_next;

         if (state == IDLE && start)
            idx <= '0;
         else if (state == NEXT)
            idx <= idx + CW'(1);

         // Terminal count leaves RUN, so the counter never wraps.
         if (state == ARM)
            beat_cnt <= '0;
         else if (state == RUN && beat && !last_beat)
            beat_cnt <= beat_cnt + BW'(1);

         if (clear)
            err_q <= 1'b0;
         else if (tbl_reject || timeout)
            err_q <= 1'b1;

         // Origin is captured while waiting for the frame, so it is stable before crop_start.
         if (state == REQ) begin
            crop_y1 <= YW'(rd_coord.y);
            crop_x1 <= XW'(rd_coord.x);
            crop_id <= idx[IW-1:0];
         end
      end
   end

   assign busy       = (state != IDLE);
   assign frame_req  = (state == REQ);
   assign crop_start = (state == ARM);
   assign crop_done  = (state == NEXT);
   assign done       = (state == FIN);
   assign err        = err_q;

endmodule
